// File: rtl/mult_div_unit.sv
// Iterative 32-bit multiply/divide unit with HI/LO registers.
// Shift-add multiply and restoring divide on magnitudes, sign-fixed in a final cycle.
module mult_div_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] rs_data,
    input  logic [WIDTH-1:0] rt_data,
    input  logic             hi_we,
    input  logic             lo_we,
    input  logic [WIDTH-1:0] wdata,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

    state_t                 state_q, state_d;
    logic                   div_q, div_d;
    logic                   neg_a_q, neg_a_d;
    logic                   neg_b_q, neg_b_d;
    logic [WIDTH-1:0]       rs_q, rs_d;
    logic [WIDTH-1:0]       mag_q, mag_d;
    logic [2*WIDTH-1:0]     acc_q, acc_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [WIDTH-1:0]       hi_q, hi_d;
    logic [WIDTH-1:0]       lo_q, lo_d;
    logic                   done_q, done_d;
    logic                   dbz_q, dbz_d;

    logic                   rs_neg, rt_neg;
    logic [WIDTH-1:0]       rs_abs, rt_abs;
    logic [WIDTH:0]         addend, sum, shifted, diff;
    logic [WIDTH-1:0]       quo, rem;
    logic [2*WIDTH-1:0]     prod;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = CALC;
            CALC:    if (cnt_q == LAST) state_d = FIX;
            FIX:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        busy = 1'b0;
        case (state_q)
            CALC, FIX: busy = 1'b1;
            default:   busy = 1'b0;
        endcase
    end

    always_comb begin
        div_d   = div_q;
        neg_a_d = neg_a_q;
        neg_b_d = neg_b_q;
        rs_d    = rs_q;
        mag_d   = mag_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        dbz_d   = dbz_q;
        done_d  = 1'b0;

        rs_neg  = ~op[0] & rs_data[WIDTH-1];
        rt_neg  = ~op[0] & rt_data[WIDTH-1];
        rs_abs  = rs_neg ? ('0 - rs_data) : rs_data;
        rt_abs  = rt_neg ? ('0 - rt_data) : rt_data;

        addend  = acc_q[0] ? {1'b0, mag_q} : '0;
        sum     = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + addend;
        shifted = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
        diff    = shifted - {1'b0, mag_q};
        quo     = acc_q[WIDTH-1:0];
        rem     = acc_q[2*WIDTH-1:WIDTH];
        prod    = (neg_a_q ^ neg_b_q) ? ('0 - acc_q) : acc_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    div_d   = op[1];
                    neg_a_d = rs_neg;
                    neg_b_d = rt_neg;
                    rs_d    = rs_data;
                    cnt_d   = '0;
                    // Divide: acc holds {remainder, dividend}; multiply: {partial, multiplier}.
                    mag_d   = op[1] ? rt_abs : rs_abs;
                    acc_d   = {{WIDTH{1'b0}}, op[1] ? rs_abs : rt_abs};
                end else begin
                    if (hi_we) hi_d = wdata;
                    if (lo_we) lo_d = wdata;
                end
            end
            CALC: begin
                cnt_d = cnt_q + 1'b1;
                if (div_q) begin
                    if (!diff[WIDTH]) acc_d = {diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
                    else              acc_d = {shifted[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
                end else begin
                    acc_d = {sum, acc_q[WIDTH-1:1]};
                end
            end
            FIX: begin
                done_d = 1'b1;
                if (div_q) begin
                    dbz_d = (mag_q == '0);
                    if (mag_q == '0) begin
                        hi_d = rs_q;
                        lo_d = '1;
                    end else begin
                        hi_d = neg_a_q ? ('0 - rem) : rem;
                        lo_d = (neg_a_q ^ neg_b_q) ? ('0 - quo) : quo;
                    end
                end else begin
                    dbz_d = 1'b0;
                    hi_d  = prod[2*WIDTH-1:WIDTH];
                    lo_d  = prod[WIDTH-1:0];
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            div_q   <= 1'b0;
            neg_a_q <= 1'b0;
            neg_b_q <= 1'b0;
            rs_q    <= '0;
            mag_q   <= '0;
            acc_q   <= '0;
            cnt_q   <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            done_q  <= 1'b0;
            dbz_q   <= 1'b0;
        end else begin
            div_q   <= div_d;
            neg_a_q <= neg_a_d;
            neg_b_q <= neg_b_d;
            rs_q    <= rs_d;
            mag_q   <= mag_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            done_q  <= done_d;
            dbz_q   <= dbz_d;
        end
    end

    assign done        = done_q;
    assign div_by_zero = dbz_q;
    assign hi          = hi_q;
    assign lo          = lo_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed and randomized bench for mult_div_unit: expected HI/LO/flag results
// are queued at issue and checked when done pulses.
module tb_mult_div_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [1:0]  op;
    logic [31:0] rs_data, rt_data, wdata;
    logic        hi_we, lo_we;
    logic        busy, done, div_by_zero;
    logic [31:0] hi, lo;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dbz;
    } exp_t;

    exp_t exp_q[$];
    int   n_assert = 0;
    int   n_fail   = 0;

    mult_div_unit #(.WIDTH(32)) dut (
        .clk(clk), .reset(reset), .start(start), .op(op),
        .rs_data(rs_data), .rt_data(rt_data),
        .hi_we(hi_we), .lo_we(lo_we), .wdata(wdata),
        .busy(busy), .done(done), .div_by_zero(div_by_zero),
        .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic exp_t model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        exp_t e;
        logic signed [63:0] sa, sb, sq, sr;
        logic [63:0] p;
        sa = {{32{a[31]}}, a};
        sb = {{32{b[31]}}, b};
        e.dbz = 1'b0;
        case (o)
            2'b00: begin p = sa * sb; e.hi = p[63:32]; e.lo = p[31:0]; end
            2'b01: begin p = {32'b0, a} * {32'b0, b}; e.hi = p[63:32]; e.lo = p[31:0]; end
            default: begin
                if (b == 32'h0) begin
                    e.hi = a; e.lo = 32'hFFFF_FFFF; e.dbz = 1'b1;
                end else if (o == 2'b10) begin
                    sq = sa / sb; sr = sa % sb;
                    e.hi = sr[31:0]; e.lo = sq[31:0];
                end else begin
                    e.hi = a % b; e.lo = a / b;
                end
            end
        endcase
        return e;
    endfunction

    // Called at a negedge; returns at the negedge following the accept edge.
    task automatic start_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                            input logic push, input exp_t e);
        start = 1'b1; op = o; rs_data = a; rt_data = b;
        if (push) exp_q.push_back(e);
        @(negedge clk);
        start = 1'b0; op = 2'($urandom); rs_data = $urandom; rt_data = $urandom;
    endtask

    task automatic wait_done(input string tag, input int lat0);
        int   lat = lat0;
        int   busy_cnt = 0;
        exp_t e;
        while (done !== 1'b1 && lat < 40) begin
            if (busy === 1'b1) busy_cnt++;
            @(negedge clk);
            lat++;
        end
        chk({tag, "_latency"}, lat, 33);
        chk({tag, "_busy_len"}, busy_cnt, 33 - lat0);
        chk({tag, "_busy_at_done"}, busy, 0);
        chk({tag, "_sb_nonempty"}, exp_q.size() != 0, 1);
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            chk({tag, "_hi"}, hi, e.hi);
            chk({tag, "_lo"}, lo, e.lo);
            chk({tag, "_dbz"}, div_by_zero, e.dbz);
        end
    endtask

    function automatic exp_t mk(input logic [31:0] h, input logic [31:0] l, input logic d);
        exp_t e;
        e.hi = h; e.lo = l; e.dbz = d;
        return e;
    endfunction

    initial begin
        exp_t e;
        logic [1:0]  ro;
        logic [31:0] ra, rb;
        int          done_seen;

        reset = 1'b1; start = 1'b0; op = 2'b00; rs_data = '0; rt_data = '0;
        hi_we = 1'b0; lo_we = 1'b0; wdata = '0;
        repeat (3) @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_dbz", div_by_zero, 0);
        chk("rst_hi", hi, 0);
        chk("rst_lo", lo, 0);
        reset = 1'b0;

        // MULTU max x max, started on the first edge after reset release
        start_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1, mk(32'hFFFF_FFFE, 32'h0000_0001, 0));
        wait_done("multu_max", 0);
        @(negedge clk);
        chk("done_one_cycle", done, 0);
        chk("hi_hold", hi, 32'hFFFF_FFFE);

        // MULT -3 x 5 with an ignored start at cycle 5
        start_op(2'b00, 32'hFFFF_FFFD, 32'h5, 1, mk(32'hFFFF_FFFF, 32'hFFFF_FFF1, 0));
        repeat (5) @(negedge clk);
        start = 1'b1; op = 2'b01; rs_data = 32'h7; rt_data = 32'h9;
        @(negedge clk);
        start = 1'b0;
        wait_done("mult_neg", 6);
        @(negedge clk);

        start_op(2'b10, 32'hFFFF_FFF9, 32'h2, 1, mk(32'hFFFF_FFFF, 32'hFFFF_FFFD, 0));
        wait_done("div_neg7", 0);
        @(negedge clk);
        start_op(2'b11, 32'h7, 32'h2, 1, mk(32'h1, 32'h3, 0));
        wait_done("divu_7_2", 0);
        @(negedge clk);
        start_op(2'b11, 32'h64, 32'h0, 1, mk(32'h64, 32'hFFFF_FFFF, 1));
        wait_done("divu_by0", 0);
        @(negedge clk);
        chk("dbz_sticky_idle", div_by_zero, 1);
        start_op(2'b00, 32'h2, 32'h2, 1, mk(32'h0, 32'h4, 0));
        wait_done("mult_2x2", 0);
        @(negedge clk);

        // Overflow divide, then back-to-back starts issued in each done cycle
        start_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 1, mk(32'h0, 32'h8000_0000, 0));
        wait_done("div_ovf", 0);
        start_op(2'b10, 32'hFFFF_FF00, 32'h0, 1, model(2'b10, 32'hFFFF_FF00, 32'h0));
        wait_done("b2b_div_by0", 0);
        for (int i = 0; i < 6; i++) begin
            ro = 2'($urandom_range(0, 3));
            ra = $urandom;
            rb = (i == 3) ? 32'h0 : ((i % 2 == 0) ? $urandom : 32'($urandom_range(1, 300)));
            if (i == 5) ra = 32'($urandom_range(0, 1000));
            start_op(ro, ra, rb, 1, model(ro, ra, rb));
            wait_done("b2b_rand", 0);
        end
        @(negedge clk);

        // Asynchronous reset in the middle of a divide
        start_op(2'b10, 32'h1234_5678, 32'h0000_0013, 0, e);
        repeat (10) @(negedge clk);
        reset = 1'b1;
        #1;
        chk("midrst_busy", busy, 0);
        chk("midrst_hi", hi, 0);
        chk("midrst_lo", lo, 0);
        chk("midrst_dbz", div_by_zero, 0);
        @(negedge clk);
        reset = 1'b0;
        done_seen = 0;
        for (int i = 0; i < 40; i++) begin
            if (done === 1'b1) done_seen++;
            @(negedge clk);
        end
        chk("midrst_no_done", done_seen, 0);
        chk("midrst_idle", busy, 0);

        // MTHI/MTLO writes while idle, discarded on start and while busy
        hi_we = 1'b1; lo_we = 1'b1; wdata = 32'h1234_5678;
        @(negedge clk);
        lo_we = 1'b0; wdata = 32'hA5A5_A5A5;
        chk("mt_both_hi", hi, 32'h1234_5678);
        chk("mt_both_lo", lo, 32'h1234_5678);
        @(negedge clk);
        hi_we = 1'b0;
        chk("mthi_hi", hi, 32'hA5A5_A5A5);
        chk("mthi_lo_kept", lo, 32'h1234_5678);
        lo_we = 1'b1; wdata = 32'hDEAD_BEEF;
        start_op(2'b01, 32'h3, 32'h4, 1, mk(32'h0, 32'hC, 0));
        lo_we = 1'b0;
        chk("mtlo_vs_start", lo, 32'h1234_5678);
        repeat (3) @(negedge clk);
        hi_we = 1'b1; wdata = 32'hFFFF_0000;
        @(negedge clk);
        hi_we = 1'b0;
        chk("mthi_busy", hi, 32'hA5A5_A5A5);
        wait_done("multu_3x4", 4);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
